vlsu_seq: RTL and testbench

Vector load/store sequencer: accepts one strided vector memory request and issues it to the 4-port byte-addressed data memory, up to four elements per cycle, one element per port. Load data is sign- or zero-extended per element and assembled into a result vector. Sits between the vector issue stage and the data memory, driving that memory's write-enable, read-enable, address and data ports.

---
 rtl/vlsu_seq.sv | 186 ++++++++++++++++++
 tb/tb_vlsu_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_seq.sv
// Strided vector load/store sequencer driving a 4-port byte-addressed data memory.
// Issues up to four elements per cycle and assembles extended load data into a result vector.
module vlsu_seq #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned VLMAX      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      reqValid,
    output logic                      reqReady,
    input  logic                      reqStore,
    input  logic [1:0]                reqEew,
    input  logic                      reqSigned,
    input  logic [ADDR_WIDTH-1:0]     reqBase,
    input  logic [ADDR_WIDTH-1:0]     reqStride,
    input  logic [$clog2(VLMAX):0]    reqVl,
    input  logic [32*VLMAX-1:0]       reqStoreData,
    output logic [2:0]                writeEnable0,
    output logic [2:0]                writeEnable1,
    output logic [2:0]                writeEnable2,
    output logic [2:0]                writeEnable3,
    output logic [2:0]                readEnable0,
    output logic [2:0]                readEnable1,
    output logic [2:0]                readEnable2,
    output logic [2:0]                readEnable3,
    output logic [ADDR_WIDTH-1:0]     addr0,
    output logic [ADDR_WIDTH-1:0]     addr1,
    output logic [ADDR_WIDTH-1:0]     addr2,
    output logic [ADDR_WIDTH-1:0]     addr3,
    output logic [31:0]               writeData0,
    output logic [31:0]               writeData1,
    output logic [31:0]               writeData2,
    output logic [31:0]               writeData3,
    input  logic [31:0]               readData0,
    input  logic [31:0]               readData1,
    input  logic [31:0]               readData2,
    input  logic [31:0]               readData3,
    output logic                      doneValid,
    output logic                      doneError,
    output logic [32*VLMAX-1:0]       loadData
);

    localparam int unsigned VlW  = $clog2(VLMAX) + 1;
    localparam int unsigned IdxW = $clog2(VLMAX);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q;
    logic                    store_q;
    logic                    signed_q;
    logic [1:0]              eew_q;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [ADDR_WIDTH-1:0]   addr_cur_q;
    logic [VlW-1:0]          vl_q;
    logic [VlW-1:0]          elem_q;
    logic [32*VLMAX-1:0]     sdata_q;
    logic [32*VLMAX-1:0]     load_q;

    logic [2:0]              code;
    logic [31:0]             mask;
    logic                    lane_act  [4];
    logic [IdxW-1:0]         lane_idx  [4];
    logic [ADDR_WIDTH-1:0]   lane_addr [4];
    logic [31:0]             lane_wd   [4];
    logic [2:0]              lane_we   [4];
    logic [2:0]              lane_re   [4];
    logic [31:0]             rd        [4];
    logic                    last_group;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] eew,
                                           input logic sgn);
        logic [31:0] r;
        case (eew)
            2'b00:   r = {{24{sgn & d[7]}}, d[7:0]};
            2'b01:   r = {{16{sgn & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign rd[0] = readData0;
    assign rd[1] = readData1;
    assign rd[2] = readData2;
    assign rd[3] = readData3;

    always_comb begin
        code = 3'b111;
        mask = 32'hFFFF_FFFF;
        case (eew_q)
            2'b00: begin code = 3'b001; mask = 32'h0000_00FF; end
            2'b01: begin code = 3'b011; mask = 32'h0000_FFFF; end
            default: ;
        endcase
    end

    // Memory-side lane signals decode only latched request state, never the req* inputs.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_idx[k]  = elem_q[IdxW-1:0] + IdxW'(k);
            lane_act[k]  = (state_q == StRun) &&
                           ((VlW+1)'(elem_q) + (VlW+1)'(k) < (VlW+1)'(vl_q));
            lane_addr[k] = '0;
            lane_wd[k]   = '0;
            lane_we[k]   = '0;
            lane_re[k]   = '0;
            if (lane_act[k]) begin
                lane_addr[k] = addr_cur_q + ADDR_WIDTH'(k) * stride_q;
                if (store_q) begin
                    lane_we[k] = code;
                    lane_wd[k] = sdata_q[32*lane_idx[k] +: 32] & mask;
                end else begin
                    lane_re[k] = code;
                end
            end
        end
    end

    assign last_group = ((VlW+1)'(elem_q) + (VlW+1)'(4)) >= (VlW+1)'(vl_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            store_q    <= 1'b0;
            signed_q   <= 1'b0;
            eew_q      <= 2'b00;
            stride_q   <= '0;
            addr_cur_q <= '0;
            vl_q       <= '0;
            elem_q     <= '0;
            sdata_q    <= '0;
            load_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (reqValid) begin
                        store_q    <= reqStore;
                        signed_q   <= reqSigned;
                        eew_q      <= reqEew;
                        stride_q   <= reqStride;
                        addr_cur_q <= reqBase;
                        vl_q       <= reqVl;
                        elem_q     <= '0;
                        sdata_q    <= reqStoreData;
                        if (!reqStore) load_q <= '0;
                        state_q    <= (reqVl == '0 || reqEew == 2'b11) ? StDone : StRun;
                    end
                end
                StRun: begin
                    for (int k = 0; k < 4; k++) begin
                        if (lane_act[k] && !store_q) begin
                            load_q[32*lane_idx[k] +: 32] <= extend(rd[k], eew_q, signed_q);
                        end
                    end
                    elem_q     <= elem_q + VlW'(4);
                    addr_cur_q <= addr_cur_q + (stride_q << 2);
                    if (last_group) state_q <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign reqReady  = (state_q == StIdle);
    assign doneValid = (state_q == StDone);
    assign doneError = (state_q == StDone) && (eew_q == 2'b11);
    assign loadData  = load_q;

    assign writeEnable0 = lane_we[0];
    assign writeEnable1 = lane_we[1];
    assign writeEnable2 = lane_we[2];
    assign writeEnable3 = lane_we[3];
    assign readEnable0  = lane_re[0];
    assign readEnable1  = lane_re[1];
    assign readEnable2  = lane_re[2];
    assign readEnable3  = lane_re[3];
    assign addr0        = lane_addr[0];
    assign addr1        = lane_addr[1];
    assign addr2        = lane_addr[2];
    assign addr3        = lane_addr[3];
    assign writeData0   = lane_wd[0];
    assign writeData1   = lane_wd[1];
    assign writeData2   = lane_wd[2];
    assign writeData3   = lane_wd[3];

endmodule

// File: tb/tb_vlsu_seq.sv
// Directed bench for vlsu_seq with a 1 KiB byte memory model; outputs sampled on the falling edge.
module tb_vlsu_seq;

    localparam int unsigned AW = 10;
    localparam int unsigned VL = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            reqValid, reqReady, reqStore, reqSigned;
    logic [1:0]      reqEew;
    logic [AW-1:0]   reqBase, reqStride;
    logic [4:0]      reqVl;
    logic [32*VL-1:0] reqStoreData;
    logic [2:0]      writeEnable0, writeEnable1, writeEnable2, writeEnable3;
    logic [2:0]      readEnable0, readEnable1, readEnable2, readEnable3;
    logic [AW-1:0]   addr0, addr1, addr2, addr3;
    logic [31:0]     writeData0, writeData1, writeData2, writeData3;
    logic [31:0]     readData0, readData1, readData2, readData3;
    logic            doneValid, doneError;
    logic [32*VL-1:0] loadData;

    int total = 0;
    int bad   = 0;

    vlsu_seq #(.ADDR_WIDTH(AW), .VLMAX(VL)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqStore(reqStore), .reqEew(reqEew),
        .reqSigned(reqSigned), .reqBase(reqBase), .reqStride(reqStride), .reqVl(reqVl),
        .reqStoreData(reqStoreData),
        .writeEnable0(writeEnable0), .writeEnable1(writeEnable1),
        .writeEnable2(writeEnable2), .writeEnable3(writeEnable3),
        .readEnable0(readEnable0), .readEnable1(readEnable1),
        .readEnable2(readEnable2), .readEnable3(readEnable3),
        .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .writeData0(writeData0), .writeData1(writeData1),
        .writeData2(writeData2), .writeData3(writeData3),
        .readData0(readData0), .readData1(readData1),
        .readData2(readData2), .readData3(readData3),
        .doneValid(doneValid), .doneError(doneError), .loadData(loadData)
    );

    always #5 clk = ~clk;

    // Memory model: combinational little-endian reads, port writes applied in order 0..3.
    logic [7:0]    mem [1024];
    logic          clr, bk_we;
    logic [AW-1:0] bk_addr;
    logic [31:0]   bk_word;
    logic [2:0]    twe [4];
    logic [AW-1:0] tad [4];
    logic [31:0]   twd [4];

    assign twe[0] = writeEnable0; assign twe[1] = writeEnable1;
    assign twe[2] = writeEnable2; assign twe[3] = writeEnable3;
    assign tad[0] = addr0; assign tad[1] = addr1; assign tad[2] = addr2; assign tad[3] = addr3;
    assign twd[0] = writeData0; assign twd[1] = writeData1;
    assign twd[2] = writeData2; assign twd[3] = writeData3;

    assign readData0 = {mem[addr0+10'd3], mem[addr0+10'd2], mem[addr0+10'd1], mem[addr0]};
    assign readData1 = {mem[addr1+10'd3], mem[addr1+10'd2], mem[addr1+10'd1], mem[addr1]};
    assign readData2 = {mem[addr2+10'd3], mem[addr2+10'd2], mem[addr2+10'd1], mem[addr2]};
    assign readData3 = {mem[addr3+10'd3], mem[addr3+10'd2], mem[addr3+10'd1], mem[addr3]};

    always @(posedge clk) begin
        if (clr) for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        if (bk_we) for (int b = 0; b < 4; b++) mem[bk_addr + AW'(b)] <= bk_word[8*b +: 8];
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 4; b++) begin
                if ((twe[p] == 3'b111) || (twe[p] == 3'b011 && b < 2) ||
                    (twe[p] == 3'b001 && b < 1))
                    mem[tad[p] + AW'(b)] <= twd[p][8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [31:0] w);
        bk_we = 1'b1; bk_addr = a; bk_word = w;
        @(posedge clk); @(negedge clk);
        bk_we = 1'b0;
    endtask

    // Called on a falling edge with the DUT idle; returns on the falling edge of cycle 1.
    task automatic issue(input logic st, input logic [1:0] eew, input logic sg,
                         input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input logic [4:0] vl);
        reqValid = 1'b1; reqStore = st; reqEew = eew; reqSigned = sg;
        reqBase = base; reqStride = stride; reqVl = vl;
        @(posedge clk); @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic ld1(input string tag, input logic [1:0] eew, input logic sg,
                       input logic [AW-1:0] base, input logic [31:0] exp);
        issue(1'b0, eew, sg, base, 10'd0, 5'd1);
        @(negedge clk);
        chk({tag, "_done"}, doneValid, 1'b1);
        chk(tag, loadData, {480'd0, exp});
        @(negedge clk);
    endtask

    logic [32*VL-1:0] exp_ld;
    logic             seen;

    initial begin
        rst_n = 1'b0; reqValid = 1'b0; reqStore = 1'b0; reqEew = 2'b00; reqSigned = 1'b0;
        reqBase = '0; reqStride = '0; reqVl = '0; reqStoreData = '0;
        clr = 1'b1; bk_we = 1'b0; bk_addr = '0; bk_word = '0;
        @(posedge clk); @(negedge clk);
        clr = 1'b0;
        chk("rst_ready", reqReady, 1'b1);
        chk("rst_done", {doneValid, doneError}, 2'b00);
        chk("rst_load", loadData, '0);
        chk("rst_mem", {readEnable0, writeEnable0, addr0, writeData0}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word load, unit stride, vl=6
        for (int i = 0; i < 6; i++) poke(AW'(10'h40 + 4*i), 32'(i + 1));
        issue(1'b0, 2'b10, 1'b0, 10'h040, 10'd4, 5'd6);
        chk("wl_ready_c1", reqReady, 1'b0);
        chk("wl_addr_c1", {addr0, addr1, addr2, addr3}, {10'h40, 10'h44, 10'h48, 10'h4C});
        chk("wl_re_c1", {readEnable0, readEnable1, readEnable2, readEnable3}, 12'hFFF);
        chk("wl_we_c1", {writeEnable0, writeEnable1, writeEnable2, writeEnable3}, 12'h000);
        @(negedge clk);
        chk("wl_re_c2", {readEnable0, readEnable1, readEnable2, readEnable3}, 12'b111_111_000_000);
        chk("wl_addr_c2", {addr0, addr1, addr2, addr3}, {10'h50, 10'h54, 10'h0, 10'h0});
        chk("wl_nodone_c2", doneValid, 1'b0);
        @(negedge clk);
        chk("wl_done_c3", {doneValid, doneError}, 2'b10);
        exp_ld = '0;
        for (int i = 0; i < 6; i++) exp_ld[32*i +: 32] = 32'(i + 1);
        chk("wl_data", loadData, exp_ld);
        @(negedge clk);
        chk("wl_idle_c4", {doneValid, reqReady}, 2'b01);

        // Load extension
        poke(10'h100, 32'h0000_0080);
        poke(10'h104, 32'h0000_8001);
        poke(10'h108, 32'h8000_0001);
        ld1("ext_b_s", 2'b00, 1'b1, 10'h100, 32'hFFFF_FF80);
        ld1("ext_b_u", 2'b00, 1'b0, 10'h100, 32'h0000_0080);
        ld1("ext_h_s", 2'b01, 1'b1, 10'h104, 32'hFFFF_8001);
        ld1("ext_h_u", 2'b01, 1'b0, 10'h104, 32'h0000_8001);
        ld1("ext_w_s", 2'b10, 1'b1, 10'h108, 32'h8000_0001);
        exp_ld = {480'd0, 32'h8000_0001};

        // Negative-stride half store
        reqStoreData = '0;
        reqStoreData[127:0] = {32'h0000_DDDD, 32'hFFFF_CCCC, 32'h0000_BBBB, 32'h1234_AAAA};
        issue(1'b1, 2'b01, 1'b0, 10'h010, 10'h3FE, 5'd4);
        chk("ns_addr", {addr0, addr1, addr2, addr3}, {10'h10, 10'h0E, 10'h0C, 10'h0A});
        chk("ns_we", {writeEnable0, writeEnable1, writeEnable2, writeEnable3}, 12'o3333);
        chk("ns_re", {readEnable0, readEnable1, readEnable2, readEnable3}, 12'h000);
        chk("ns_wd", {writeData0, writeData1, writeData2, writeData3},
            {32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD});
        @(negedge clk);
        chk("ns_done", {doneValid, doneError}, 2'b10);
        chk("ns_mem", {mem[10'h11], mem[10'h10], mem[10'h0F], mem[10'h0E],
                       mem[10'h0D], mem[10'h0C], mem[10'h0B], mem[10'h0A]},
            64'hAAAA_BBBB_CCCC_DDDD);
        chk("ns_load_kept", loadData, exp_ld);
        @(negedge clk);

        // Degenerate requests
        issue(1'b1, 2'b10, 1'b0, 10'h020, 10'd4, 5'd0);
        chk("vl0_done", {doneValid, doneError}, 2'b10);
        chk("vl0_en", {writeEnable0, writeEnable1, writeEnable2, writeEnable3,
                       readEnable0, readEnable1, readEnable2, readEnable3}, 24'h0);
        @(negedge clk);
        chk("vl0_idle", {doneValid, reqReady}, 2'b01);
        issue(1'b1, 2'b11, 1'b0, 10'h020, 10'd4, 5'd5);
        chk("eew3_done", {doneValid, doneError}, 2'b11);
        chk("eew3_en", {writeEnable0, writeEnable1, writeEnable2, writeEnable3,
                        readEnable0, readEnable1, readEnable2, readEnable3}, 24'h0);
        @(negedge clk);
        chk("eew3_idle", {doneValid, doneError, reqReady}, 3'b001);
        chk("deg_load_kept", loadData, exp_ld);

        // Address wrap, then stride-0 overlap
        reqStoreData = '0;
        reqStoreData[63:0] = {32'h5566_7788, 32'h1122_3344};
        issue(1'b1, 2'b10, 1'b0, 10'h3FC, 10'd4, 5'd2);
        chk("wrap_addr", {addr0, addr1, addr2}, {10'h3FC, 10'h000, 10'h000});
        chk("wrap_we", {writeEnable0, writeEnable1, writeEnable2}, 9'o770);
        @(negedge clk);
        chk("wrap_mem", {mem[3], mem[2], mem[1], mem[0], mem[10'h3FF], mem[10'h3FC]},
            48'h5566_7788_1144);
        @(negedge clk);
        reqStoreData = '0;
        reqStoreData[127:0] = {32'd4, 32'd3, 32'd2, 32'd1};
        issue(1'b1, 2'b00, 1'b0, 10'h200, 10'd0, 5'd4);
        chk("ovl_we", {writeEnable0, writeEnable3}, 6'o11);
        @(negedge clk);
        chk("ovl_mem", {mem[10'h200], mem[10'h201]}, 16'h0400);
        @(negedge clk);

        // Reset during the second RUN cycle of a 16-element load
        issue(1'b0, 2'b10, 1'b0, 10'h040, 10'd4, 5'd16);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem", {readEnable0, readEnable3, addr0, addr1}, '0);
        chk("mid_rst_done", {doneValid, doneError}, 2'b00);
        chk("mid_rst_load", loadData, '0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); seen = seen | doneValid; end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); seen = seen | doneValid; end
        chk("mid_rst_nodone", seen, 1'b0);
        chk("mid_rst_ready", reqReady, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 10'h040, 10'd4, 5'd4);
        chk("post_rst_re", {readEnable0, readEnable3, addr3}, {3'b111, 3'b111, 10'h04C});
        @(negedge clk);
        chk("post_rst_done", {doneValid, doneError}, 2'b10);
        chk("post_rst_load", loadData, {384'd0, 32'd4, 32'd3, 32'd2, 32'd1});
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
